// File: rtl/spi_req_arbiter_pkg.sv
// Shared definitions for the spi request arbiter: FSM state encoding and the
// ceiling-log2 helper used to size the pointer and watchdog counter.
package spi_req_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Bits needed to index 'value' items; never less than 1.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((value - 1) >= (1 << k)) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or above the
// pointer, wrapping, reported as one-hot, index and an any-request flag.
module spi_req_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        j        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Scan from the farthest slot back to the pointer so the nearest wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (i_req[j]) begin
                o_any       = 1'b1;
                o_idx       = IW'(j);
                o_onehot    = '0;
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sequencer sharing one spi master between NREQ requesters.
// Optional watchdog and tmo_err port are built when SPI_ARB_TIMEOUT_EN is defined.
module spi_req_arbiter
    import spi_req_arbiter_pkg::*;
#(
    parameter int BITS = 8,
    parameter int NREQ = 4,
    parameter int TMO  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_clr,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [BITS-1:0]      rx_data,
    output logic                 busy,
    output logic                 spi_en,
    output logic                 spi_clr_ctrl,
    output logic [BITS-1:0]      spi_data2trans,
    input  logic                 spi_ss,
    input  logic [BITS-1:0]      spi_data_rec
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    output logic                 tmo_err
`endif
);

    localparam int IW = clogb2(NREQ);

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_idx;
    logic              r_clr;
    logic [BITS-1:0]   r_data2trans;
    logic [BITS-1:0]   r_rx_data;
    logic [NREQ-1:0]   w_pick_onehot;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_can_grant;
    logic              w_timeout;
    logic              w_tmo_done;

    spi_req_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Gating with rst keeps the combinational grant outputs quiet during reset.
    assign w_can_grant = w_pick_any & rst;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = clogb2(TMO + 1);

    logic [CW-1:0] r_cnt;
    logic          r_tmo_done;
    logic          r_tmo_err;
    logic          w_waiting;

    assign w_waiting = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH) ||
                       (r_state == ST_CAPTURE);
    assign w_timeout = w_waiting && (r_cnt == CW'(TMO - 1));
    assign w_tmo_done = r_tmo_done;
    assign tmo_err = r_tmo_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_tmo_done <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_tmo_done <= w_timeout;
            if (r_state == ST_LAUNCH) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_can_grant && (r_state == ST_IDLE)) begin
                r_tmo_err <= 1'b0;
            end else if (w_timeout) begin
                r_tmo_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_tmo_done = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        gnt          = '0;
        done         = '0;
        busy         = 1'b1;
        spi_en       = 1'b0;
        spi_clr_ctrl = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = w_can_grant;
                if (w_can_grant) begin
                    gnt          = w_pick_onehot;
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                spi_en       = 1'b1;
                spi_clr_ctrl = r_clr;
                w_state_next = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (w_timeout) begin
                    w_state_next = ST_DONE;
                end else if (!spi_ss) begin
                    w_state_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_timeout) begin
                    w_state_next = ST_DONE;
                end else if (spi_ss) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Master publishes data_rec one cycle after ss rises.
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done[r_idx]  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_clr        <= 1'b0;
            r_data2trans <= '0;
            r_rx_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_can_grant) begin
                r_idx        <= w_pick_idx;
                r_clr        <= req_clr[w_pick_idx];
                r_data2trans <= req_data[w_pick_idx*BITS +: BITS];
            end
            if (r_state == ST_DONE) begin
                r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                if (!w_tmo_done) begin
                    r_rx_data <= spi_data_rec;
                end
            end
        end
    end

    assign spi_data2trans = r_data2trans;
    assign rx_data        = r_rx_data;

endmodule
